// File: rtl/fma16_normalizer_if.sv
// Handshake bundle between the fma16 adder, the normalizer and the rounding unit.
// master = the side that feeds sums in and drains results; slave = the normalizer.
interface fma16_normalizer_if;
  logic        in_valid;
  logic        in_ready;
  logic [43:0] in_sum;
  logic [6:0]  in_exp;
  logic        in_sign;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [43:0] out_frac;
  logic [6:0]  out_exp;
  logic        out_sign;
  logic        out_sticky;
  logic        out_zero;
  logic        out_denorm;

  modport master (
    output in_valid, in_sum, in_exp, in_sign, in_sticky, out_ready,
    input  in_ready, out_valid, out_frac, out_exp, out_sign, out_sticky,
           out_zero, out_denorm
  );

  modport slave (
    input  in_valid, in_sum, in_exp, in_sign, in_sticky, out_ready,
    output in_ready, out_valid, out_frac, out_exp, out_sign, out_sticky,
           out_zero, out_denorm
  );
endinterface

// File: rtl/fma16_normalizer.sv
// Iterative normalizer ahead of the fma16 rounder: puts the leading one on bit 32
// using a single right shift or repeated 4-bit / 1-bit left shifts.
module fma16_normalizer (
  input logic clk,
  input logic reset,
  fma16_normalizer_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic [43:0]       frac_q;
  logic signed [6:0] exp_q;
  logic              sign_q;
  logic              sticky_q;
  logic              zero_q;
  logic              denorm_q;

  logic              lead_hi;
  logic [3:0]        shamt;
  logic [43:0]       right_frac;
  logic              right_lost;

  // Highest set bit above the hidden position decides the one-shot right shift.
  always_comb begin
    lead_hi = 1'b0;
    shamt   = 4'd0;
    for (int i = 33; i < 44; i++) begin
      if (frac_q[i]) begin
        lead_hi = 1'b1;
        shamt   = 4'(i - 32);
      end
    end
    right_frac = frac_q >> shamt;
    right_lost = |(frac_q & ((44'd1 << shamt) - 44'd1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      frac_q   <= 44'd0;
      exp_q    <= 7'sd0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            frac_q   <= bus.in_sum;
            exp_q    <= $signed(bus.in_exp);
            sign_q   <= bus.in_sign;
            sticky_q <= bus.in_sticky;
            zero_q   <= 1'b0;
            denorm_q <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (frac_q == 44'd0) begin
            exp_q  <= 7'sd0;
            zero_q <= 1'b1;
            state  <= DONE;
          end else if (lead_hi) begin
            frac_q   <= right_frac;
            exp_q    <= exp_q + $signed({3'b000, shamt});
            sticky_q <= sticky_q | right_lost;
          end else if (frac_q[32]) begin
            state <= DONE;
          end else if (exp_q <= 7'sd1) begin
            // Exponent floor reached: hand a subnormal to the rounder as-is.
            denorm_q <= 1'b1;
            state    <= DONE;
          end else if (frac_q[32:29] == 4'd0 && exp_q >= 7'sd5) begin
            frac_q <= frac_q << 4;
            exp_q  <= exp_q - 7'sd4;
          end else begin
            frac_q <= frac_q << 1;
            exp_q  <= exp_q - 7'sd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_frac   = frac_q;
  assign bus.out_exp    = exp_q;
  assign bus.out_sign   = sign_q;
  assign bus.out_sticky = sticky_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_denorm = denorm_q;

endmodule

// File: tb/tb_fma16_normalizer.sv
// Bench for fma16_normalizer: directed vector table, hand sequences for
// backpressure and mid-operation reset, then random sums against a closed-form model.
module tb_fma16_normalizer;

  typedef struct {
    logic [43:0] sum;
    logic [6:0]  exp;
    logic        sign;
    logic        sticky;
    logic [43:0] x_frac;
    logic [6:0]  x_exp;
    logic        x_sticky;
    logic        x_zero;
    logic        x_denorm;
    int          x_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[9];

  always #5 clk = ~clk;

  fma16_normalizer_if bus ();

  fma16_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Closed-form model: find the leading one, then count how many 4-bit and 1-bit
  // left steps fit above the exponent floor instead of stepping cycle by cycle.
  function automatic vec_t ref_model(input logic [43:0] sum, input logic [6:0] e,
                                     input logic sign, input logic st);
    vec_t v;
    int p, ex, d, c, fi, s;
    logic [43:0] one;
    one = 44'd1;
    v.sum = sum; v.exp = e; v.sign = sign; v.sticky = st;
    v.x_zero = 1'b0; v.x_denorm = 1'b0; v.x_sticky = st;
    p = -1;
    for (int i = 0; i < 44; i++) if (sum[i]) p = i;
    ex = int'($signed(e));
    if (p < 0) begin
      v.x_frac = 44'd0; v.x_exp = 7'd0; v.x_zero = 1'b1; v.x_lat = 1;
    end else if (p > 32) begin
      s = p - 32;
      v.x_frac   = sum >> s;
      v.x_sticky = st | ((sum % (one << s)) != 44'd0);
      v.x_exp    = 7'(ex + s);
      v.x_lat    = 2;
    end else begin
      d = 32 - p;
      c = 0;
      if (ex >= 5) c = ((d / 4) < ((ex - 1) / 4)) ? d / 4 : (ex - 1) / 4;
      ex = ex - 4 * c;
      d  = d - 4 * c;
      fi = 0;
      if (ex > 1) fi = (d < ex - 1) ? d : ex - 1;
      ex = ex - fi;
      d  = d - fi;
      v.x_frac   = sum << (4 * c + fi);
      v.x_exp    = 7'(ex);
      v.x_denorm = (d > 0);
      v.x_lat    = 1 + c + fi;
    end
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    for (int k = 0; k < 20 && !bus.in_ready; k++) @(negedge clk);
    check_val("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_sum    = v.sum;
    bus.in_exp    = v.exp;
    bus.in_sign   = v.sign;
    bus.in_sticky = v.sticky;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input vec_t v, input int hold);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
    check_val({tag, ".latency"}, 64'(lat), 64'(v.x_lat));
    check_val({tag, ".frac"},   64'(bus.out_frac),   64'(v.x_frac));
    check_val({tag, ".exp"},    64'(bus.out_exp),    64'(v.x_exp));
    check_val({tag, ".sign"},   64'(bus.out_sign),   64'(v.sign));
    check_val({tag, ".sticky"}, 64'(bus.out_sticky), 64'(v.x_sticky));
    check_val({tag, ".zero"},   64'(bus.out_zero),   64'(v.x_zero));
    check_val({tag, ".denorm"}, 64'(bus.out_denorm), 64'(v.x_denorm));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_val({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      check_val({tag, ".hold_ready"}, 64'(bus.in_ready), 64'd0);
      check_val({tag, ".hold_frac"},  64'(bus.out_frac), 64'(v.x_frac));
      check_val({tag, ".hold_exp"},   64'(bus.out_exp),  64'(v.x_exp));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val({tag, ".back_to_idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input vec_t v, input int hold);
    applyStimulus(v);
    checkOutput(tag, v, hold);
  endtask

  initial begin
    vec_t v;
    logic [63:0] r;
    logic [43:0] one, mask, sum;
    int pos;

    vecs[0] = '{44'h1_0000_0000, 7'd15, 1'b0, 1'b0, 44'h1_0000_0000, 7'd15, 1'b0, 1'b0, 1'b0, 1};
    vecs[1] = '{44'h4_0000_0001, 7'd10, 1'b0, 1'b0, 44'h1_0000_0000, 7'd12, 1'b1, 1'b0, 1'b0, 2};
    vecs[2] = '{44'h0_0000_0001, 7'd40, 1'b0, 1'b0, 44'h1_0000_0000, 7'd8,  1'b0, 1'b0, 1'b0, 9};
    vecs[3] = '{44'h0_0010_0000, 7'd3,  1'b0, 1'b0, 44'h0_0040_0000, 7'd1,  1'b0, 1'b0, 1'b1, 3};
    vecs[4] = '{44'h0,           7'd20, 1'b1, 1'b0, 44'h0,           7'd0,  1'b0, 1'b1, 1'b0, 1};
    vecs[5] = '{44'h800_0000_0000, 7'd0, 1'b0, 1'b0, 44'h1_0000_0000, 7'd11, 1'b0, 1'b0, 1'b0, 2};
    vecs[6] = '{44'h0_8000_0000, 7'h7B, 1'b1, 1'b1, 44'h0_8000_0000, 7'h7B, 1'b1, 1'b0, 1'b1, 1};
    vecs[7] = '{44'h12_0000_0000, 7'd60, 1'b0, 1'b0, 44'h1_2000_0000, 7'h40, 1'b0, 1'b0, 1'b0, 2};
    vecs[8] = '{44'h0_0200_0000, 7'd7,  1'b0, 1'b0, 44'h0_8000_0000, 7'd1,  1'b0, 1'b0, 1'b1, 4};

    bus.in_valid = 1'b0; bus.in_sum = 44'd0; bus.in_exp = 7'd0;
    bus.in_sign = 1'b0; bus.in_sticky = 1'b0; bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_val("reset.in_ready",  64'(bus.in_ready),  64'd1);
    check_val("reset.out_valid", 64'(bus.out_valid), 64'd0);
    check_val("reset.out_frac",  64'(bus.out_frac),  64'd0);
    check_val("reset.out_exp",   64'(bus.out_exp),   64'd0);
    check_val("reset.out_zero",  64'(bus.out_zero),  64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vecs[i], 0);

    // Backpressure, with a stray in_valid during DONE that must be ignored.
    applyStimulus(vecs[1]);
    bus.in_valid = 1'b1;
    bus.in_sum   = 44'h0_0000_0FFF;
    checkOutput("bp", vecs[1], 5);
    bus.in_valid = 1'b0;
    check_val("bp.no_extra_accept", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of the long coarse-shift sequence.
    applyStimulus(vecs[2]);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("midreset.out_valid", 64'(bus.out_valid), 64'd0);
    check_val("midreset.in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    reset = 1'b0;
    check_val("midreset.in_ready_after", 64'(bus.in_ready), 64'd1);
    run_op("after_reset", vecs[3], 0);

    one = 44'd1;
    for (int n = 0; n < 200; n++) begin
      pos = int'($urandom_range(0, 44));
      r = {$urandom(), $urandom()};
      if (pos == 44) sum = 44'd0;
      else begin
        mask = (one << pos) - one;
        sum  = (r[43:0] & mask) | (one << pos);
      end
      v = ref_model(sum, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      run_op($sformatf("rnd%0d", n), v, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish, want finish before 500000");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
